// File: rtl/priv_issue_ctrl_pkg.sv
// priv_issue_ctrl_pkg: shared uop class indices, FSM encoding and defaults for the privileged issue controller
package priv_issue_ctrl_pkg;
   localparam int WIDTH_UOP = 5;
   localparam int INS_CSR   = 0;
   localparam int INS_ERTN  = 1;
   localparam int INS_IDLE  = 2;
   localparam int INS_CACHE = 3;
   localparam int INS_TLB   = 4;
   localparam int PRIV_TIMEOUT_DEFAULT = 1023;
   typedef enum logic [2:0] {PI_IDLE, PI_DRAIN, PI_EXEC, PI_WB, PI_FLUSH} pi_state_e;
   function automatic logic [31:0] seq_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction
endpackage

// File: rtl/priv_issue_ctrl_if.sv
// priv_issue_ctrl_if: dispatch, engine, write-back and flush signals of the privileged issue controller
// slave  = controller side (consumes dispatch/engine inputs, drives engine/wb/flush outputs)
// master = environment side (dispatch, retire status, CSR.ERA and execute engine)
interface priv_issue_ctrl_if import priv_issue_ctrl_pkg::*; #(parameter int UOP_W = WIDTH_UOP) ();
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_pc;
   logic [31:0]      in_ins;
   logic [UOP_W-1:0] in_pr_type;
   logic [4:0]       in_rd;
   logic [31:0]      in_rj_data;
   logic [31:0]      in_rk_data;
   logic             pipe_empty;
   logic             flush_in;
   logic [31:0]      era;
   logic             pr_en;
   logic [31:0]      pr_ins;
   logic [UOP_W-1:0] pr_type;
   logic [31:0]      pr_rj_data;
   logic [31:0]      pr_rk_data;
   logic             pr_done;
   logic [31:0]      pr_csr_rdata;
   logic             wb_valid;
   logic [4:0]       wb_rd;
   logic [31:0]      wb_data;
   logic             flush_by_priv;
   logic [31:0]      redirect_pc;
   logic             priv_timeout;
   modport slave (
      input  in_valid, in_pc, in_ins, in_pr_type, in_rd, in_rj_data, in_rk_data,
      input  pipe_empty, flush_in, era, pr_done, pr_csr_rdata,
      output in_ready, pr_en, pr_ins, pr_type, pr_rj_data, pr_rk_data,
      output wb_valid, wb_rd, wb_data, flush_by_priv, redirect_pc, priv_timeout
   );
   modport master (
      output in_valid, in_pc, in_ins, in_pr_type, in_rd, in_rj_data, in_rk_data,
      output pipe_empty, flush_in, era, pr_done, pr_csr_rdata,
      input  in_ready, pr_en, pr_ins, pr_type, pr_rj_data, pr_rk_data,
      input  wb_valid, wb_rd, wb_data, flush_by_priv, redirect_pc, priv_timeout
   );
endinterface

// File: rtl/priv_issue_ctrl_watchdog.sv
// priv_issue_ctrl_watchdog: EXEC-phase cycle counter; expire is high while enabled and the count equals TIMEOUT
// clr clears the count, en advances it one per cycle
module priv_issue_ctrl_watchdog import priv_issue_ctrl_pkg::*; #(
   parameter int CNT_W   = 10,
   parameter int TIMEOUT = PRIV_TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_comb begin
      cnt_d = clr ? '0 : en ? cnt_q + CNT_W'(1) : cnt_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
   assign expire = en & (cnt_q == CNT_W'(TIMEOUT));
endmodule

// File: rtl/priv_issue_ctrl.sv
// priv_issue_ctrl: serialising issue of one privileged uop: drain older work, run the engine, write back, flush
// clk/rst: clock and async active-high reset; bus: dispatch, engine, write-back and redirect signals
module priv_issue_ctrl import priv_issue_ctrl_pkg::*; #(
   parameter int UOP_W   = WIDTH_UOP,
   parameter int TIMEOUT = PRIV_TIMEOUT_DEFAULT,
   parameter int CNT_W   = 10
) (
   input logic clk,
   input logic rst,
   priv_issue_ctrl_if.slave bus
);
   pi_state_e        state_q, state_d;
   logic [31:0]      pc_q, pc_d, ins_q, ins_d, rj_q, rj_d, rk_q, rk_d, wb_data_q, wb_data_d;
   logic [UOP_W-1:0] type_q, type_d;
   logic [4:0]       rd_q, rd_d;
   logic             to_q, to_d;
   logic             expire;
   priv_issue_ctrl_watchdog #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_wdog (
      .clk   (clk),
      .rst   (rst),
      .clr   (state_q != PI_EXEC),
      .en    (state_q == PI_EXEC),
      .expire(expire)
   );
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ins_d     = ins_q;
      type_d    = type_q;
      rd_d      = rd_q;
      rj_d      = rj_q;
      rk_d      = rk_q;
      wb_data_d = wb_data_q;
      to_d      = to_q;
      case (state_q)
         PI_IDLE:
            if (bus.in_valid && !bus.flush_in) begin
               pc_d    = bus.in_pc;
               ins_d   = bus.in_ins;
               type_d  = bus.in_pr_type;
               rd_d    = bus.in_rd;
               rj_d    = bus.in_rj_data;
               rk_d    = bus.in_rk_data;
               to_d    = 1'b0;
               state_d = PI_DRAIN;
            end
         PI_DRAIN: state_d = bus.flush_in ? PI_IDLE : bus.pipe_empty ? PI_EXEC : PI_DRAIN;
         // flush_in is deliberately not looked at here: once issued the uop commits
         PI_EXEC:
            if (bus.pr_done) begin
               wb_data_d = bus.pr_csr_rdata;
               to_d      = 1'b0;
               state_d   = PI_WB;
            end else if (expire) begin
               wb_data_d = '0;
               to_d      = 1'b1;
               state_d   = PI_WB;
            end
         PI_WB:   state_d = PI_FLUSH;
         default: state_d = PI_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= PI_IDLE;
         pc_q      <= '0;
         ins_q     <= '0;
         type_q    <= '0;
         rd_q      <= '0;
         rj_q      <= '0;
         rk_q      <= '0;
         wb_data_q <= '0;
         to_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ins_q     <= ins_d;
         type_q    <= type_d;
         rd_q      <= rd_d;
         rj_q      <= rj_d;
         rk_q      <= rk_d;
         wb_data_q <= wb_data_d;
         to_q      <= to_d;
      end
   end
   assign bus.in_ready      = state_q == PI_IDLE;
   // drops in the done cycle so the engine is never re-triggered
   assign bus.pr_en         = (state_q == PI_EXEC) & ~bus.pr_done;
   assign bus.pr_ins        = ins_q;
   assign bus.pr_type       = type_q;
   assign bus.pr_rj_data    = rj_q;
   assign bus.pr_rk_data    = rk_q;
   assign bus.wb_valid      = (state_q == PI_WB) & type_q[INS_CSR] & (|rd_q) & ~to_q;
   assign bus.wb_rd         = rd_q;
   assign bus.wb_data       = wb_data_q;
   assign bus.flush_by_priv = state_q == PI_FLUSH;
   // ERTN returns to the live ERA value; everything else resumes at the next sequential PC
   assign bus.redirect_pc   = (state_q == PI_FLUSH) ? (type_q[INS_ERTN] ? bus.era : seq_pc(pc_q)) : '0;
   assign bus.priv_timeout  = expire & ~bus.pr_done;
endmodule
